// File: rtl/pixel_encoder_if.sv
// Pixel-in / line-out handshake bundle for the pixel encoder.
interface pixel_encoder_if;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        flush;
    logic [23:0] line_out;
    logic        line_valid;
    logic        line_ready;
    logic        line_last;
    logic [7:0]  line_idx;

    // Encoder side
    modport slave (
        input  pixel_in, pixel_valid, flush, line_ready,
        output pixel_ready, line_out, line_valid, line_last, line_idx
    );

    // Upstream pixel source and downstream line writer side
    modport master (
        output pixel_in, pixel_valid, flush, line_ready,
        input  pixel_ready, line_out, line_valid, line_last, line_idx
    );
endinterface

// File: rtl/pixel_encoder.sv
// Quantises 8-bit pixels to 1 bit and packs 24 of them into a line word.
// Assembly register plus output holding register, so intake continues while
// a finished line waits for the writer.
module pixel_encoder #(
    parameter int unsigned BP    = 0,
    parameter int unsigned LINES = 24
) (
    input  logic            clk,
    input  logic            rstn,
    pixel_encoder_if.slave  bus
);

    localparam int unsigned LINE_W = 24;
    localparam int unsigned COL_W  = 5;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned PIX_W  = 8;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LINE_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LINES - 1);
    localparam logic [PIX_W-1:0] PIX_THRESH = PIX_W'(1 << BP);

    logic [COL_W-1:0]  col_q,        col_n;
    logic [LINE_W-1:0] asm_q,        asm_n;
    logic              pend_q,       pend_n;
    logic              ready_en_q;
    logic [IDX_W-1:0]  cnt_q,        cnt_n;
    logic [LINE_W-1:0] line_out_q,   line_out_n;
    logic              line_valid_q, line_valid_n;
    logic              line_last_q,  line_last_n;
    logic [IDX_W-1:0]  line_idx_q,   line_idx_n;

    logic              q_bit;
    logic              free_c;
    logic              ready_c;
    logic              accept_c;
    logic              close_c;
    logic              want_flush_c;
    logic [COL_W-1:0]  col_acc_c;
    logic [LINE_W-1:0] asm_acc_c;

    // Ready and close decisions; next values for every register
    always_comb begin
        q_bit        = (bus.pixel_in >= PIX_THRESH);
        free_c       = !line_valid_q || bus.line_ready;
        ready_c      = ready_en_q && !pend_q && !((col_q == COL_LAST) && !free_c);
        accept_c     = bus.pixel_valid && ready_c;

        asm_acc_c    = asm_q;
        col_acc_c    = col_q;
        if (accept_c) begin
            col_acc_c = col_q + COL_W'(1);
            if (q_bit) begin
                asm_acc_c = asm_q | (LINE_W'(1) << col_q);
            end
        end

        want_flush_c = (bus.flush || pend_q) && (col_acc_c != '0);
        close_c      = free_c && ((accept_c && (col_q == COL_LAST)) || want_flush_c);

        col_n        = col_acc_c;
        asm_n        = asm_acc_c;
        pend_n       = pend_q;
        cnt_n        = cnt_q;
        line_out_n   = line_out_q;
        line_valid_n = line_valid_q;
        line_last_n  = line_last_q;
        line_idx_n   = line_idx_q;

        if (line_valid_q && bus.line_ready) begin
            line_valid_n = 1'b0;
        end

        if (close_c) begin
            line_out_n   = asm_acc_c;
            line_valid_n = 1'b1;
            line_idx_n   = cnt_q;
            line_last_n  = (cnt_q == IDX_LAST);
            cnt_n        = (cnt_q == IDX_LAST) ? '0 : cnt_q + IDX_W'(1);
            col_n        = '0;
            asm_n        = '0;
            pend_n       = 1'b0;
        end else if (want_flush_c) begin
            // Output register busy: hold the flush until it frees up
            pend_n = 1'b1;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q        <= '0;
            asm_q        <= '0;
            pend_q       <= 1'b0;
            ready_en_q   <= 1'b0;
            cnt_q        <= '0;
            line_out_q   <= '0;
            line_valid_q <= 1'b0;
            line_last_q  <= 1'b0;
            line_idx_q   <= '0;
        end else begin
            col_q        <= col_n;
            asm_q        <= asm_n;
            pend_q       <= pend_n;
            ready_en_q   <= 1'b1;
            cnt_q        <= cnt_n;
            line_out_q   <= line_out_n;
            line_valid_q <= line_valid_n;
            line_last_q  <= line_last_n;
            line_idx_q   <= line_idx_n;
        end
    end

    assign bus.pixel_ready = ready_c;
    assign bus.line_out    = line_out_q;
    assign bus.line_valid  = line_valid_q;
    assign bus.line_last   = line_last_q;
    assign bus.line_idx    = line_idx_q;

endmodule

// File: tb/tb_pixel_encoder.sv
// Directed bench for pixel_encoder: two instances (BP=0/LINES=24 and
// BP=3/LINES=4) share one stimulus stream; each test checks one of them.
module tb_pixel_encoder;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  pix;
    logic        pv;
    logic        flush;
    logic        lr;
    bit          sel;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_stalls = 0;

    logic        rdy;
    logic [23:0] lo;
    logic        lv;
    logic        llast;
    logic [7:0]  lidx;

    pixel_encoder_if ifa ();
    pixel_encoder_if ifb ();

    assign ifa.pixel_in    = pix;
    assign ifa.pixel_valid = pv;
    assign ifa.flush       = flush;
    assign ifa.line_ready  = lr;
    assign ifb.pixel_in    = pix;
    assign ifb.pixel_valid = pv;
    assign ifb.flush       = flush;
    assign ifb.line_ready  = lr;

    pixel_encoder #(.BP(0), .LINES(24)) u_dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
    pixel_encoder #(.BP(3), .LINES(4))  u_dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

    always #5 clk = ~clk;

    // Observe the instance under test
    always_comb begin
        if (sel) begin
            rdy = ifb.pixel_ready; lo = ifb.line_out; lv = ifb.line_valid;
            llast = ifb.line_last; lidx = ifb.line_idx;
        end else begin
            rdy = ifa.pixel_ready; lo = ifa.line_out; lv = ifa.line_valid;
            llast = ifa.line_last; lidx = ifa.line_idx;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; pv = 1'b0; flush = 1'b0; lr = 1'b0; pix = 8'h00;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    // Offer one pixel and hold it until accepted (bounded)
    task automatic push(input logic [7:0] v);
        int n = 0;
        pix = v;
        pv  = 1'b1;
        #1;
        while (!rdy && n < 50) begin
            step();
            n++;
            n_stalls++;
        end
        if (n >= 50) check_val("push_timeout", 32'(rdy), 32'd1);
        step();
        pv = 1'b0;
    endtask

    task automatic push_word(input logic [23:0] w);
        for (int k = 0; k < 24; k++) push(w[k] ? 8'hFF : 8'h00);
    endtask

    localparam logic [23:0] L0 = 24'hA5C3F0;
    localparam logic [23:0] L1 = 24'h3C96E1;

    initial begin
        sel = 1'b0;
        rstn = 1'b0; pv = 1'b0; flush = 1'b0; lr = 1'b0; pix = 8'h00;
        #2;
        check_val("rst_ready", 32'(rdy), 32'd0);
        check_val("rst_valid", 32'(lv), 32'd0);
        check_val("rst_out",   32'(lo), 32'd0);
        check_val("rst_idx",   32'(lidx), 32'd0);
        check_val("rst_last",  32'(llast), 32'd0);
        step();
        step();
        rstn = 1'b1;
        step();
        check_val("post_rst_ready", 32'(rdy), 32'd1);

        // 1: alternating pixels, BP=0, writer always ready
        lr = 1'b1;
        n_stalls = 0;
        for (int k = 0; k < 24; k++) push((k % 2 == 0) ? 8'h01 : 8'h00);
        check_val("t1_valid", 32'(lv), 32'd1);
        check_val("t1_out",   32'(lo), 32'h555555);
        check_val("t1_idx",   32'(lidx), 32'd0);
        check_val("t1_stall", 32'(n_stalls), 32'd0);
        step();
        check_val("t1_valid_1clk", 32'(lv), 32'd0);

        // 2: BP=3 quantisation threshold
        do_reset();
        sel = 1'b1;
        lr  = 1'b1;
        push(8'd8); push(8'd7); push(8'd255); push(8'd0);
        for (int k = 0; k < 20; k++) push(8'h10);
        check_val("t2_valid", 32'(lv), 32'd1);
        check_val("t2_out",   32'(lo), 32'hFFFFF5);

        // 3: writer stalled across two lines, then one drain cycle
        do_reset();
        sel = 1'b0;
        push_word(L0);
        for (int k = 0; k < 23; k++) push(L1[k] ? 8'hFF : 8'h00);
        pix = L1[23] ? 8'hFF : 8'h00;
        pv  = 1'b1;
        #1;
        check_val("t3_stall_ready", 32'(rdy), 32'd0);
        step();
        check_val("t3_hold_ready", 32'(rdy), 32'd0);
        check_val("t3_hold_out",   32'(lo), 32'(L0));
        check_val("t3_hold_idx",   32'(lidx), 32'd0);
        check_val("t3_hold_valid", 32'(lv), 32'd1);
        lr = 1'b1;
        #1;
        check_val("t3_drain_ready", 32'(rdy), 32'd1);
        step();
        pv = 1'b0;
        check_val("t3_l1_out",   32'(lo), 32'(L1));
        check_val("t3_l1_idx",   32'(lidx), 32'd1);
        check_val("t3_l1_valid", 32'(lv), 32'd1);
        step();
        check_val("t3_l1_drained", 32'(lv), 32'd0);

        // 4: flush of a partial line, empty flush, pending flush
        do_reset();
        for (int k = 0; k < 5; k++) push(8'hFF);
        flush = 1'b1; step(); flush = 1'b0;
        check_val("t4_valid", 32'(lv), 32'd1);
        check_val("t4_out",   32'(lo), 32'h00001F);
        check_val("t4_idx",   32'(lidx), 32'd0);
        flush = 1'b1; step(); flush = 1'b0;
        check_val("t4_empty_out", 32'(lo), 32'h00001F);
        check_val("t4_empty_idx", 32'(lidx), 32'd0);
        push(8'hFF); push(8'hFF);
        flush = 1'b1; step(); flush = 1'b0;
        check_val("t4_pend_ready", 32'(rdy), 32'd0);
        check_val("t4_pend_out",   32'(lo), 32'h00001F);
        flush = 1'b1; step(); flush = 1'b0;
        lr = 1'b1;
        #1;
        check_val("t4_pend_ready_lr", 32'(rdy), 32'd0);
        step();
        check_val("t4_pend_close_out", 32'(lo), 32'h000003);
        check_val("t4_pend_close_idx", 32'(lidx), 32'd1);
        check_val("t4_pend_close_vld", 32'(lv), 32'd1);
        step();
        check_val("t4_drained", 32'(lv), 32'd0);
        step();
        check_val("t4_no_extra", 32'(lv), 32'd0);
        check_val("t4_ready_back", 32'(rdy), 32'd1);

        // 5: line index wrap with LINES=4
        do_reset();
        sel = 1'b1;
        lr  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_word(24'hFFFFFF);
            check_val($sformatf("t5_idx%0d", i),  32'(lidx), 32'(i % 4));
            check_val($sformatf("t5_last%0d", i), 32'(llast), 32'((i % 4) == 3));
            check_val($sformatf("t5_out%0d", i),  32'(lo), 32'hFFFFFF);
        end

        // 6: async reset with a pending line and a partial line
        do_reset();
        sel = 1'b0;
        push_word(24'hFFFFFF);
        for (int k = 0; k < 10; k++) push(8'hFF);
        rstn = 1'b0;
        #1;
        check_val("t6_rst_valid", 32'(lv), 32'd0);
        check_val("t6_rst_ready", 32'(rdy), 32'd0);
        check_val("t6_rst_out",   32'(lo), 32'd0);
        step();
        rstn = 1'b1;
        step();
        check_val("t6_ready", 32'(rdy), 32'd1);
        lr = 1'b1;
        push_word(24'h000F00);
        check_val("t6_out",   32'(lo), 32'h000F00);
        check_val("t6_idx",   32'(lidx), 32'd0);
        check_val("t6_valid", 32'(lv), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
